pipe_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage core. It drives the shared stall bus and the per-register flush (bubble) strobes that sequence the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves four hazard sources:
- load-use data hazards;
- taken branches and jumps resolved in EX;
- multi-cycle instruction-memory fetches;
- multi-cycle data-memory accesses, with a watchdog on the data-memory access.

---
 rtl/pipe_ctrl_pkg.sv | 38 +++
 rtl/pipe_ctrl_if.sv | 53 +++++
 rtl/pipe_ctrl_wdog.sv | 52 +++++
 rtl/pipe_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard/stall controller: stall bus
// layout, canned stall patterns, FSM state encoding and a sizing helper
// for the data-memory watchdog.
// Ports: none (package).
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    // Controller FSM: normal flow, or holding the pipe for a data access
    typedef enum logic {
        RUN   = 1'b0,
        DWAIT = 1'b1
    } ctrlState_e;

    // Stall bus layout; a set bit means that register holds its value
    localparam int STALL_W      = 6;
    localparam int STALL_PC     = 0;
    localparam int STALL_IF_ID  = 1;
    localparam int STALL_ID_EX  = 2;
    localparam int STALL_EX_MEM = 3;
    localparam int STALL_MEM_WB = 4;
    localparam int STALL_RSVD   = 5;

    // Fetch wait: only the PC holds, IF/ID takes a bubble
    localparam logic [STALL_W-1:0] STALL_FETCH    = STALL_W'(1 << STALL_PC);
    // Load-use: PC and IF/ID hold, ID/EX takes a bubble
    localparam logic [STALL_W-1:0] STALL_LOAD_USE = STALL_W'((1 << STALL_PC) | (1 << STALL_IF_ID));
    // Data-memory wait: everything up to EX/MEM holds, MEM/WB takes a bubble
    localparam logic [STALL_W-1:0] STALL_DMEM     = STALL_W'((1 << STALL_PC) | (1 << STALL_IF_ID) |
                                                             (1 << STALL_ID_EX) | (1 << STALL_EX_MEM));

    // The watchdog must be able to hold the value DMEM_TIMEOUT itself
    function automatic int wdogWidth(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Bundles the hazard inputs from the pipeline and the stall/flush outputs of
// the controller.
// Modports:
//   master - the controller: reads hazard inputs, drives stall/flush/counter
//   slave  - the pipeline:   drives hazard inputs, reads stall/flush/counter
// Signals:
//   id_r1/id_r2, id_r1_en/id_r2_en  source operands of the ID instruction
//   ex_rd, ex_mem_re, ex_br_taken   EX-stage destination, load flag, redirect
//   imem_req/imem_ack               instruction fetch handshake
//   dmem_req/dmem_ack               data access handshake
//   stall_o                         per-register hold bus
//   flush_if_id/id_ex/mem_wb        per-register bubble strobes
//   dmem_timeout                    data access abort pulse
//   stall_cnt                       PC-stall cycle counter
// -----------------------------------------------------------------------------
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipe_ctrl_pkg::*;

    logic [4:0]         id_r1;
    logic [4:0]         id_r2;
    logic               id_r1_en;
    logic               id_r2_en;
    logic [4:0]         ex_rd;
    logic               ex_mem_re;
    logic               ex_br_taken;
    logic               imem_req;
    logic               imem_ack;
    logic               dmem_req;
    logic               dmem_ack;
    logic [STALL_W-1:0] stall_o;
    logic               flush_if_id;
    logic               flush_id_ex;
    logic               flush_mem_wb;
    logic               dmem_timeout;
    logic [CNT_W-1:0]   stall_cnt;

    modport master (
        input  id_r1, id_r2, id_r1_en, id_r2_en, ex_rd, ex_mem_re, ex_br_taken,
               imem_req, imem_ack, dmem_req, dmem_ack,
        output stall_o, flush_if_id, flush_id_ex, flush_mem_wb, dmem_timeout, stall_cnt
    );

    modport slave (
        output id_r1, id_r2, id_r1_en, id_r2_en, ex_rd, ex_mem_re, ex_br_taken,
               imem_req, imem_ack, dmem_req, dmem_ack,
        input  stall_o, flush_if_id, flush_id_ex, flush_mem_wb, dmem_timeout, stall_cnt
    );

endinterface

// File: rtl/pipe_ctrl_wdog.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_wdog
// Counts stalled cycles of the current data-memory access.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load_i       start of a new access: count becomes 1
//   inc_i        another stalled cycle: count + 1
//   clr_i        access finished or aborted: count becomes 0
//   at_limit_o   count has reached LIMIT
// -----------------------------------------------------------------------------
module pipe_ctrl_wdog #(
    parameter int LIMIT = 255,
    parameter int W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins over load, load over increment, so a finishing access
    // never leaves a stale count behind
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = W'(1);
        end else if (inc_i) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_limit_o = (count_q == LIMIT_V);

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Hazard and stall controller for the 5-stage core. Resolves data-memory
// waits (with watchdog abort), EX-resolved branches, load-use hazards and
// instruction-fetch waits into a stall bus and per-register bubble strobes.
// Ports:
//   clk, rst   clock, synchronous active-high reset (forces outputs to 0)
//   bus        pipe_ctrl_if.master: hazard inputs in, stall/flush/count out
// Parameters:
//   DMEM_TIMEOUT  maximum stalled cycles per data access (>= 1)
//   CNT_W         width of the stall cycle counter
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 255,
    parameter int CNT_W        = 32
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.master  bus
);

    localparam int WDOG_W = wdogWidth(DMEM_TIMEOUT);

    ctrlState_e         state_q, state_d;
    logic               killPend_q, killPend_d;
    logic [CNT_W-1:0]   stallCnt_q, stallCnt_d;

    logic               wdogLoad, wdogInc, wdogClr, wdogAtLimit;
    logic               fetchWait, loadUse, dmemHold, dmemAbort;

    logic [STALL_W-1:0] stallBus;
    logic               flushIfId, flushIdEx, flushMemWb, dmemTimeout;

    pipe_ctrl_wdog #(
        .LIMIT (DMEM_TIMEOUT),
        .W     (WDOG_W)
    ) uWdog (
        .clk        (clk),
        .rst        (rst),
        .load_i     (wdogLoad),
        .inc_i      (wdogInc),
        .clr_i      (wdogClr),
        .at_limit_o (wdogAtLimit)
    );

    // Raw hazard conditions. While waiting on data memory the hold lasts
    // until ack, unless the watchdog has run out, in which case it is an abort.
    assign fetchWait = bus.imem_req & ~bus.imem_ack;
    assign loadUse   = bus.ex_mem_re & (bus.ex_rd != 5'd0) &
                       ((bus.id_r1_en & (bus.id_r1 == bus.ex_rd)) |
                        (bus.id_r2_en & (bus.id_r2 == bus.ex_rd)));
    assign dmemHold  = (state_q == RUN) ? (bus.dmem_req & ~bus.dmem_ack)
                                        : (~bus.dmem_ack & ~wdogAtLimit);
    assign dmemAbort = (state_q == DWAIT) & ~bus.dmem_ack & wdogAtLimit;

    // Priority resolution and FSM next state. A data-memory hold freezes the
    // whole front of the pipe, so branch/load-use/fetch terms are only looked
    // at once it is released or aborted. A fetch that is still in flight when
    // a branch redirects is remembered so its late return can be bubbled out;
    // the kill waits until IF/ID is no longer held.
    always_comb begin
        stallBus    = '0;
        flushIfId   = 1'b0;
        flushIdEx   = 1'b0;
        flushMemWb  = 1'b0;
        dmemTimeout = 1'b0;
        state_d     = state_q;
        killPend_d  = killPend_q;
        wdogLoad    = 1'b0;
        wdogInc     = 1'b0;
        wdogClr     = 1'b0;

        if (dmemHold) begin
            stallBus   = STALL_DMEM;
            flushMemWb = 1'b1;
            if (state_q == RUN) begin
                state_d  = DWAIT;
                wdogLoad = 1'b1;
            end else begin
                wdogInc = 1'b1;
            end
        end else begin
            if (bus.ex_br_taken) begin
                flushIfId = 1'b1;
                flushIdEx = 1'b1;
                if (fetchWait) begin
                    killPend_d = 1'b1;
                end
            end else if (loadUse) begin
                stallBus  = STALL_LOAD_USE;
                flushIdEx = 1'b1;
            end else if (fetchWait) begin
                stallBus  = STALL_FETCH;
                flushIfId = 1'b1;
            end

            if (killPend_q && bus.imem_ack && !stallBus[STALL_IF_ID]) begin
                flushIfId  = 1'b1;
                killPend_d = 1'b0;
            end

            if (dmemAbort) begin
                dmemTimeout = 1'b1;
                flushMemWb  = 1'b1;
            end

            if (state_q == DWAIT) begin
                state_d = RUN;
                wdogClr = 1'b1;
            end
        end

        if (rst) begin
            stallBus    = '0;
            flushIfId   = 1'b0;
            flushIdEx   = 1'b0;
            flushMemWb  = 1'b0;
            dmemTimeout = 1'b0;
        end
    end

    assign stallCnt_d = stallCnt_q + CNT_W'(stallBus[STALL_PC]);

    // State, pending-kill flag and performance counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            killPend_q <= 1'b0;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            killPend_q <= killPend_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign bus.stall_o      = stallBus;
    assign bus.flush_if_id  = flushIfId;
    assign bus.flush_id_ex  = flushIdEx;
    assign bus.flush_mem_wb = flushMemWb;
    assign bus.dmem_timeout = dmemTimeout;
    assign bus.stall_cnt    = rst ? '0 : stallCnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl: directed scenarios for each hazard
// source plus a randomized run against a cycle-level reference model.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CW      = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    pipe_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_ctrl #(
        .DMEM_TIMEOUT (TIMEOUT),
        .CNT_W        (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Packs the observed outputs as {stall_o, flush_if_id, flush_id_ex, flush_mem_wb, dmem_timeout}
    function automatic logic [9:0] outs();
        return {bus.stall_o, bus.flush_if_id, bus.flush_id_ex, bus.flush_mem_wb, bus.dmem_timeout};
    endfunction

    // Advance one clock; inputs are changed 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive all hazard inputs inactive
    task automatic idle();
        bus.id_r1 = '0; bus.id_r2 = '0; bus.id_r1_en = 1'b0; bus.id_r2_en = 1'b0;
        bus.ex_rd = '0; bus.ex_mem_re = 1'b0; bus.ex_br_taken = 1'b0;
        bus.imem_req = 1'b0; bus.imem_ack = 1'b0; bus.dmem_req = 1'b0; bus.dmem_ack = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reset forces everything to zero even with every hazard active
    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        bus.dmem_req = 1'b1; bus.ex_br_taken = 1'b1; bus.imem_req = 1'b1;
        bus.ex_mem_re = 1'b1; bus.ex_rd = 5'd7; bus.id_r1 = 5'd7; bus.id_r1_en = 1'b1;
        #2;
        checks++;
        if (outs() !== 10'h000) begin
            failures++; $display("[TB] FAIL reset_outs got=%h exp=%h", outs(), 10'h000);
        end
        checks++;
        if (bus.stall_cnt !== 8'd0) begin
            failures++; $display("[TB] FAIL reset_cnt got=%0d exp=0", bus.stall_cnt);
        end
        tick();
        rst = 1'b0;
        idle();
        #2;
        checks++;
        if (outs() !== 10'h000 || bus.stall_cnt !== 8'd0) begin
            failures++; $display("[TB] FAIL post_reset got=%h cnt=%0d exp=000 cnt=0", outs(), bus.stall_cnt);
        end
    endtask

    // Load-use on r1, on r2, with rd=0 and with enables off
    task automatic test_load_use();
        logic [9:0] e;
        doReset();
        bus.ex_mem_re = 1'b1; bus.ex_rd = 5'd5; bus.id_r1 = 5'd5; bus.id_r1_en = 1'b1;
        e = {6'h03, 4'b0100};
        #2;
        checks++;
        if (outs() !== e) begin
            failures++; $display("[TB] FAIL load_use_r1 got=%h exp=%h", outs(), e);
        end
        tick();
        checks++;
        if (bus.stall_cnt !== 8'd1) begin
            failures++; $display("[TB] FAIL load_use_cnt got=%0d exp=1", bus.stall_cnt);
        end
        bus.ex_rd = 5'd0; bus.id_r1 = 5'd0;
        #2;
        checks++;
        if (outs() !== 10'h000) begin
            failures++; $display("[TB] FAIL load_use_rd0 got=%h exp=%h", outs(), 10'h000);
        end
        tick();
        bus.ex_rd = 5'd9; bus.id_r1 = 5'd9; bus.id_r1_en = 1'b0; bus.id_r2 = 5'd9; bus.id_r2_en = 1'b1;
        #2;
        checks++;
        if (outs() !== e) begin
            failures++; $display("[TB] FAIL load_use_r2 got=%h exp=%h", outs(), e);
        end
        tick();
        bus.id_r2_en = 1'b0;
        #2;
        checks++;
        if (outs() !== 10'h000 || bus.stall_cnt !== 8'd2) begin
            failures++; $display("[TB] FAIL load_use_noen got=%h cnt=%0d exp=000 cnt=2", outs(), bus.stall_cnt);
        end
        idle();
    endtask

    // Branch wins over a simultaneous load-use
    task automatic test_branch_load_use();
        logic [9:0] e;
        doReset();
        bus.ex_mem_re = 1'b1; bus.ex_rd = 5'd3; bus.id_r2 = 5'd3; bus.id_r2_en = 1'b1;
        bus.ex_br_taken = 1'b1;
        e = {6'h00, 4'b1100};
        #2;
        checks++;
        if (outs() !== e) begin
            failures++; $display("[TB] FAIL branch_load_use got=%h exp=%h", outs(), e);
        end
        tick();
        idle();
    endtask

    // Data access acked on its fourth cycle
    task automatic test_dmem_ack();
        logic [9:0] e;
        doReset();
        bus.dmem_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.dmem_ack = (k == 3);
            e = (k < 3) ? {6'h0F, 4'b0010} : 10'h000;
            #2;
            checks++;
            if (outs() !== e) begin
                failures++; $display("[TB] FAIL dmem_ack_cyc%0d got=%h exp=%h", k, outs(), e);
            end
            tick();
        end
        idle();
        #2;
        checks++;
        if (outs() !== 10'h000 || bus.stall_cnt !== 8'd3) begin
            failures++; $display("[TB] FAIL dmem_ack_after got=%h cnt=%0d exp=000 cnt=3", outs(), bus.stall_cnt);
        end
    endtask

    // Data access that never acks: TIMEOUT stalled cycles then an abort
    task automatic test_dmem_timeout();
        logic [9:0] e;
        doReset();
        bus.dmem_req = 1'b1;
        for (int k = 0; k <= TIMEOUT; k++) begin
            e = (k < TIMEOUT) ? {6'h0F, 4'b0010} : {6'h00, 4'b0011};
            #2;
            checks++;
            if (outs() !== e) begin
                failures++; $display("[TB] FAIL dmem_timeout_cyc%0d got=%h exp=%h", k, outs(), e);
            end
            tick();
        end
        idle();
        #2;
        checks++;
        if (outs() !== 10'h000 || bus.stall_cnt !== 8'(TIMEOUT)) begin
            failures++; $display("[TB] FAIL dmem_timeout_after got=%h cnt=%0d exp=000 cnt=%0d", outs(), bus.stall_cnt, TIMEOUT);
        end
    endtask

    // Branch during an outstanding fetch kills the late fetch on return
    task automatic test_kill();
        logic [2:0] stim [9] = '{3'b010, 3'b110, 3'b010, 3'b011, 3'b010, 3'b011, 3'b111, 3'b010, 3'b011};
        logic [9:0] expv [9] = '{{6'h01, 4'b1000}, {6'h00, 4'b1100}, {6'h01, 4'b1000},
                                 {6'h00, 4'b1000}, {6'h01, 4'b1000}, {6'h00, 4'b0000},
                                 {6'h00, 4'b1100}, {6'h01, 4'b1000}, {6'h00, 4'b0000}};
        doReset();
        for (int k = 0; k < 9; k++) begin
            {bus.ex_br_taken, bus.imem_req, bus.imem_ack} = stim[k];
            #2;
            checks++;
            if (outs() !== expv[k]) begin
                failures++; $display("[TB] FAIL kill_step%0d got=%h exp=%h", k, outs(), expv[k]);
            end
            tick();
        end
        idle();
    endtask

    // Reset during a data wait drops the access; a new one restarts the watchdog
    task automatic test_reset_mid_dwait();
        logic [9:0] e;
        doReset();
        bus.dmem_req = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #2;
        checks++;
        if (outs() !== 10'h000 || bus.stall_cnt !== 8'd0) begin
            failures++; $display("[TB] FAIL mid_dwait_rst got=%h cnt=%0d exp=000 cnt=0", outs(), bus.stall_cnt);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k <= TIMEOUT; k++) begin
            e = (k < TIMEOUT) ? {6'h0F, 4'b0010} : {6'h00, 4'b0011};
            #2;
            checks++;
            if (outs() !== e || bus.stall_cnt !== 8'(k)) begin
                failures++; $display("[TB] FAIL mid_dwait_restart%0d got=%h cnt=%0d exp=%h cnt=%0d", k, outs(), bus.stall_cnt, e, k);
            end
            tick();
        end
        idle();
    endtask

    // Random inputs against a cycle model built from the hazard rules
    task automatic test_random(input int n);
        int         waited;
        bit         killPending;
        int         cnt;
        bit         hold, abortNow, fetchWait, luse;
        logic [5:0] eStall;
        logic       eFif, eFie, eFmw, eTmo;
        logic [9:0] e;
        doReset();
        waited = 0; killPending = 1'b0; cnt = 0;
        for (int i = 0; i < n; i++) begin
            rst              = ($urandom_range(0, 59) == 0);
            bus.id_r1        = 5'($urandom_range(0, 3));
            bus.id_r2        = 5'($urandom_range(0, 3));
            bus.id_r1_en     = 1'($urandom_range(0, 1));
            bus.id_r2_en     = 1'($urandom_range(0, 1));
            bus.ex_rd        = 5'($urandom_range(0, 3));
            bus.ex_mem_re    = 1'($urandom_range(0, 1));
            bus.ex_br_taken  = ($urandom_range(0, 5) == 0);
            bus.imem_req     = 1'($urandom_range(0, 1));
            bus.imem_ack     = ($urandom_range(0, 2) == 0);
            bus.dmem_req     = (waited > 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 4) == 0);
            bus.dmem_ack     = ($urandom_range(0, 5) == 0);

            eStall = 6'h00; eFif = 1'b0; eFie = 1'b0; eFmw = 1'b0; eTmo = 1'b0;
            if (rst) begin
                waited = 0; killPending = 1'b0; cnt = 0;
            end else begin
                hold     = !bus.dmem_ack && ((waited > 0) ? (waited < TIMEOUT) : bus.dmem_req);
                abortNow = (waited == TIMEOUT) && !bus.dmem_ack;
                if (hold) begin
                    eStall = 6'h0F; eFmw = 1'b1; waited++;
                end else begin
                    waited    = 0;
                    fetchWait = bus.imem_req && !bus.imem_ack;
                    luse      = bus.ex_mem_re && bus.ex_rd != 0 &&
                                ((bus.id_r1_en && bus.id_r1 == bus.ex_rd) || (bus.id_r2_en && bus.id_r2 == bus.ex_rd));
                    if (bus.ex_br_taken) begin
                        eFif = 1'b1; eFie = 1'b1;
                        if (fetchWait) killPending = 1'b1;
                    end else if (luse) begin
                        eStall = 6'h03; eFie = 1'b1;
                    end else if (fetchWait) begin
                        eStall = 6'h01; eFif = 1'b1;
                    end
                    if (killPending && bus.imem_ack && !eStall[1]) begin
                        eFif = 1'b1; killPending = 1'b0;
                    end
                    if (abortNow) begin
                        eTmo = 1'b1; eFmw = 1'b1;
                    end
                end
            end
            e = {eStall, eFif, eFie, eFmw, eTmo};
            #2;
            checks++;
            if (outs() !== e) begin
                failures++; $display("[TB] FAIL random_outs%0d got=%h exp=%h", i, outs(), e);
            end
            checks++;
            if (bus.stall_cnt !== 8'(cnt)) begin
                failures++; $display("[TB] FAIL random_cnt%0d got=%0d exp=%0d", i, bus.stall_cnt, cnt % 256);
            end
            tick();
            if (!rst) cnt = (cnt + int'(eStall[0])) % 256;
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        $display("[TB] starting pipe_ctrl bench");
        test_reset();
        test_load_use();
        test_branch_load_use();
        test_dmem_ack();
        test_dmem_timeout();
        test_kill();
        test_reset_mid_dwait();
        test_random(600);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
